// File: rtl/taxi_eth_phy_10g_link_ctrl.sv
// rtl/taxi_eth_phy_10g_link_ctrl.sv - 10G PHY link bring-up, qualification and PRBS test-mode controller
module taxi_eth_phy_10g_link_ctrl #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 8,
   parameter int DROP_CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  restart,
   input  logic                  prbs_mode,
   input  logic                  rx_block_lock,
   input  logic                  rx_high_ber,
   input  logic                  rx_status,
   input  logic                  phy_reset_req,
   output logic                  serdes_rx_reset,
   output logic                  tx_force_idle,
   output logic                  cfg_tx_prbs31_enable,
   output logic                  cfg_rx_prbs31_enable,
   output logic                  link_up,
   output logic                  link_fail,
   output logic [2:0]            state,
   output logic [3:0]            retry_count,
   output logic [DROP_CNT_W-1:0] link_drop_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET     = 3'd1,
      WAIT_LOCK = 3'd2,
      STABILIZE = 3'd3,
      UP        = 3'd4,
      FAILED    = 3'd5,
      TEST      = 3'd6
   } state_t;

   // One shared timer; its terminal value never exceeds the longest interval minus one.
   localparam int MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
   localparam int MAX_T = (MAX_A > RESET_CYCLES) ? MAX_A : RESET_CYCLES;
   localparam int TW    = (MAX_T > 2) ? $clog2(MAX_T) : 1;

   localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STAB_LAST = TW'(STABLE_CYCLES - 1);
   localparam logic [3:0]    MAX_R     = 4'(MAX_RETRIES);

   state_t                  st, ns;
   logic [TW-1:0]           timer, timer_n;
   logic [3:0]              retry_n;
   logic [DROP_CNT_W-1:0]   drop_n;
   logic                    lock_ok;

   assign state   = st;
   assign lock_ok = rx_block_lock && !rx_high_ber;

   always_comb begin
      ns      = st;
      timer_n = timer;
      retry_n = retry_count;
      drop_n  = link_drop_count;
      if (!enable) begin
         ns      = IDLE;
         timer_n = '0;
         retry_n = '0;
      end else if (prbs_mode && st != TEST) begin
         ns      = TEST;
         timer_n = '0;
      end else if (restart) begin
         ns      = RESET;
         timer_n = '0;
         retry_n = '0;
      end else begin
         case (st)
            IDLE: begin
               ns      = RESET;
               timer_n = '0;
               retry_n = '0;
            end
            RESET: begin
               if (timer == RST_LAST) begin
                  ns      = WAIT_LOCK;
                  timer_n = '0;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            WAIT_LOCK: begin
               // Lock seen on the timeout cycle still wins over the retry.
               if (lock_ok) begin
                  ns      = STABILIZE;
                  timer_n = '0;
               end else if (timer == LOCK_LAST) begin
                  retry_n = retry_count + 1'b1;
                  timer_n = '0;
                  ns      = (retry_n == MAX_R) ? FAILED : RESET;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            STABILIZE: begin
               if (!lock_ok) begin
                  ns      = WAIT_LOCK;
                  timer_n = '0;
               end else if (!rx_status) begin
                  timer_n = '0;
               end else if (timer == STAB_LAST) begin
                  ns      = UP;
                  timer_n = '0;
                  retry_n = '0;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            UP: begin
               if (!lock_ok || phy_reset_req) begin
                  ns      = RESET;
                  timer_n = '0;
                  drop_n  = (link_drop_count == '1) ? link_drop_count : link_drop_count + 1'b1;
               end
            end
            FAILED: ns = FAILED;
            TEST: begin
               if (!prbs_mode) begin
                  ns      = RESET;
                  timer_n = '0;
                  retry_n = '0;
               end
            end
            default: begin
               ns      = IDLE;
               timer_n = '0;
               retry_n = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they change on the same edge as the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st                   <= IDLE;
         timer                <= '0;
         retry_count          <= '0;
         link_drop_count      <= '0;
         serdes_rx_reset      <= 1'b0;
         tx_force_idle        <= 1'b1;
         cfg_tx_prbs31_enable <= 1'b0;
         cfg_rx_prbs31_enable <= 1'b0;
         link_up              <= 1'b0;
         link_fail            <= 1'b0;
      end else begin
         st                   <= ns;
         timer                <= timer_n;
         retry_count          <= retry_n;
         link_drop_count      <= drop_n;
         serdes_rx_reset      <= (ns == RESET);
         tx_force_idle        <= (ns != UP);
         cfg_tx_prbs31_enable <= (ns == TEST);
         cfg_rx_prbs31_enable <= (ns == TEST);
         link_up              <= (ns == UP);
         link_fail            <= (ns == FAILED);
      end
   end

endmodule

// File: tb/tb_taxi_eth_phy_10g_link_ctrl.sv
// tb/tb_taxi_eth_phy_10g_link_ctrl.sv - directed scenario bench for the 10G link controller
module tb_taxi_eth_phy_10g_link_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, restart, prbs_mode;
   logic       rx_block_lock, rx_high_ber, rx_status, phy_reset_req;
   logic       serdes_rx_reset, tx_force_idle, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable;
   logic       link_up, link_fail;
   logic [2:0] state;
   logic [3:0] retry_count;
   logic [1:0] link_drop_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   taxi_eth_phy_10g_link_ctrl #(
      .RESET_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .MAX_RETRIES(3), .DROP_CNT_W(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart), .prbs_mode(prbs_mode),
      .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_status(rx_status),
      .phy_reset_req(phy_reset_req), .serdes_rx_reset(serdes_rx_reset), .tx_force_idle(tx_force_idle),
      .cfg_tx_prbs31_enable(cfg_tx_prbs31_enable), .cfg_rx_prbs31_enable(cfg_rx_prbs31_enable),
      .link_up(link_up), .link_fail(link_fail), .state(state), .retry_count(retry_count),
      .link_drop_count(link_drop_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state === s) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (state === s) ok = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; restart = 1'b0; prbs_mode = 1'b0;
      rx_block_lock = 1'b0; rx_high_ber = 1'b0; rx_status = 1'b0; phy_reset_req = 1'b0;
      tick(); tick();
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++;
      if ({serdes_rx_reset, link_up, link_fail, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, tx_force_idle} !== 6'b000001) begin
         errors++; $display("FAIL reset_outputs got=%b exp=000001",
            {serdes_rx_reset, link_up, link_fail, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, tx_force_idle});
      end
      checks++;
      if (retry_count !== 4'd0 || link_drop_count !== 2'd0) begin
         errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", retry_count, link_drop_count);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_bring_up();
      int n;
      rx_status = 1'b1;
      enable = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (serdes_rx_reset) n++;
         else if (n > 0) break;
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL bring_up_pulse_len got=%0d exp=4", n); end
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL bring_up_wait_lock got=%0d exp=2", state); end
      repeat (19) tick();
      rx_block_lock = 1'b1;
      tick();
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL bring_up_stabilize got=%0d exp=3", state); end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (link_up) break;
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL bring_up_latency got=%0d exp=8", n); end
      checks++;
      if (tx_force_idle !== 1'b0 || state !== 3'd4 || retry_count !== 4'd0) begin
         errors++; $display("FAIL bring_up_up got=idle%0d/st%0d/rt%0d exp=idle0/st4/rt0", tx_force_idle, state, retry_count);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      logic [3:0] last_retry;
      int pulses;
      logic prev;
      enable = 1'b0;
      rx_block_lock = 1'b0;
      tick();
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL timeout_idle got=%0d exp=0", state); end
      enable = 1'b1;
      cyc = 0; pulses = 0; prev = 1'b0; last_retry = 4'd0;
      while (!link_fail && cyc < 1000) begin
         tick();
         cyc++;
         if (serdes_rx_reset && !prev) pulses++;
         prev = serdes_rx_reset;
         if (retry_count !== last_retry) begin
            checks++;
            if (retry_count !== last_retry + 4'd1) begin
               errors++; $display("FAIL timeout_retry_step got=%0d exp=%0d", retry_count, last_retry + 4'd1);
            end
            last_retry = retry_count;
         end
      end
      checks++; if (cyc !== 109) begin errors++; $display("FAIL timeout_cycles got=%0d exp=109", cyc); end
      checks++; if (pulses !== 3) begin errors++; $display("FAIL timeout_pulses got=%0d exp=3", pulses); end
      checks++;
      if (state !== 3'd5 || retry_count !== 4'd3) begin
         errors++; $display("FAIL timeout_failed got=st%0d/rt%0d exp=st5/rt3", state, retry_count);
      end
      rx_block_lock = 1'b1;
      repeat (5) tick();
      checks++;
      if (link_fail !== 1'b1 || state !== 3'd5) begin
         errors++; $display("FAIL failed_hold got=lf%0d/st%0d exp=lf1/st5", link_fail, state);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (state !== 3'd1 || retry_count !== 4'd0 || link_fail !== 1'b0) begin
         errors++; $display("FAIL restart got=st%0d/rt%0d/lf%0d exp=st1/rt0/lf0", state, retry_count, link_fail);
      end
   endtask

   task automatic test_glitch();
      bit ok;
      int n;
      rx_block_lock = 1'b1; rx_status = 1'b1;
      wait_state(3'd3, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL glitch_reach_stab got=%0d exp=3", state); end
      repeat (3) tick();
      phy_reset_req = 1'b1;
      tick();
      phy_reset_req = 1'b0;
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL phy_req_ignored got=%0d exp=3", state); end
      rx_block_lock = 1'b0;
      tick();
      checks++;
      if (state !== 3'd2 || retry_count !== 4'd0) begin
         errors++; $display("FAIL stab_lock_loss got=st%0d/rt%0d exp=st2/rt0", state, retry_count);
      end
      rx_block_lock = 1'b1;
      tick();
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL stab_reenter got=%0d exp=3", state); end
      repeat (6) tick();
      rx_status = 1'b0;
      tick();
      rx_status = 1'b1;
      checks++;
      if (state !== 3'd3 || link_up !== 1'b0) begin
         errors++; $display("FAIL glitch_hold got=st%0d/up%0d exp=st3/up0", state, link_up);
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (link_up) break;
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL glitch_latency got=%0d exp=8", n); end
   endtask

   task automatic test_link_drop();
      bit ok;
      checks++; if (link_drop_count !== 2'd0) begin errors++; $display("FAIL drop_init got=%0d exp=0", link_drop_count); end
      rx_high_ber = 1'b1;
      tick();
      rx_high_ber = 1'b0;
      checks++;
      if (link_up !== 1'b0 || tx_force_idle !== 1'b1 || serdes_rx_reset !== 1'b1 || state !== 3'd1 || link_drop_count !== 2'd1) begin
         errors++; $display("FAIL drop_ber got=up%0d/idle%0d/rst%0d/st%0d/cnt%0d exp=up0/idle1/rst1/st1/cnt1",
            link_up, tx_force_idle, serdes_rx_reset, state, link_drop_count);
      end
      wait_state(3'd4, 60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_reup1 got=%0d exp=4", state); end
      phy_reset_req = 1'b1;
      tick();
      phy_reset_req = 1'b0;
      checks++;
      if (link_up !== 1'b0 || serdes_rx_reset !== 1'b1 || link_drop_count !== 2'd2) begin
         errors++; $display("FAIL drop_phy_req got=up%0d/rst%0d/cnt%0d exp=up0/rst1/cnt2", link_up, serdes_rx_reset, link_drop_count);
      end
      for (int k = 0; k < 3; k++) begin
         wait_state(3'd4, 60, ok);
         checks++; if (!ok) begin errors++; $display("FAIL drop_reup_loop got=%0d exp=4", state); end
         rx_high_ber = 1'b1;
         tick();
         rx_high_ber = 1'b0;
      end
      checks++; if (link_drop_count !== 2'd3) begin errors++; $display("FAIL drop_saturate got=%0d exp=3", link_drop_count); end
   endtask

   task automatic test_prbs();
      bit ok;
      wait_state(3'd4, 60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL prbs_reach_up got=%0d exp=4", state); end
      prbs_mode = 1'b1;
      tick();
      checks++;
      if (state !== 3'd6 || cfg_tx_prbs31_enable !== 1'b1 || cfg_rx_prbs31_enable !== 1'b1 || link_up !== 1'b0 || tx_force_idle !== 1'b1) begin
         errors++; $display("FAIL prbs_enter got=st%0d/tx%0d/rx%0d/up%0d/idle%0d exp=st6/tx1/rx1/up0/idle1",
            state, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, link_up, tx_force_idle);
      end
      rx_block_lock = 1'b0; phy_reset_req = 1'b1;
      tick();
      rx_block_lock = 1'b1; phy_reset_req = 1'b0;
      checks++; if (state !== 3'd6) begin errors++; $display("FAIL prbs_ignore_status got=%0d exp=6", state); end
      prbs_mode = 1'b0;
      tick();
      checks++;
      if (state !== 3'd1 || cfg_tx_prbs31_enable !== 1'b0 || cfg_rx_prbs31_enable !== 1'b0) begin
         errors++; $display("FAIL prbs_exit got=st%0d/tx%0d/rx%0d exp=st1/tx0/rx0", state, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable);
      end
   endtask

   task automatic test_priority_and_reset();
      enable = 1'b0; restart = 1'b1; prbs_mode = 1'b1;
      tick();
      restart = 1'b0; prbs_mode = 1'b0;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL priority_idle got=%0d exp=0", state); end
      enable = 1'b1;
      tick();
      tick();
      checks++;
      if (state !== 3'd1 || serdes_rx_reset !== 1'b1) begin
         errors++; $display("FAIL mid_pulse_setup got=st%0d/rst%0d exp=st1/rst1", state, serdes_rx_reset);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (serdes_rx_reset !== 1'b0 || link_drop_count !== 2'd0 || retry_count !== 4'd0 || state !== 3'd0 || tx_force_idle !== 1'b1) begin
         errors++; $display("FAIL async_reset got=rst%0d/cnt%0d/rt%0d/st%0d/idle%0d exp=rst0/cnt0/rt0/st0/idle1",
            serdes_rx_reset, link_drop_count, retry_count, state, tx_force_idle);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_bring_up();
      test_timeout();
      test_glitch();
      test_link_drop();
      test_prbs();
      test_priority_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
